mxv_cmd_parser: RTL

MXV_CMD_PARSER -- requirements
Module: mxv_cmd_parser

---
 rtl/mxv_cmd_parser_if.sv | 26 ++
 rtl/mxv_cmd_parser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mxv_cmd_parser_if.sv
// Byte-stream and FIFO-side bus of the matrix/vector command parser.
// The parser is the slave: it takes bytes from the receiver and drives the FIFO/control side.
interface mxv_cmd_parser_if #(
  parameter int DW   = 8,
  parameter int NMAX = 8
);
  logic [DW-1:0]   rx_data;
  logic            rx_flag;
  logic [DW-1:0]   fifo_data;
  logic [NMAX:0]   push;
  logic [3:0]      n_size;
  logic            start_mxv;
  logic            resend;
  logic [2:0]      comando;
  logic            frame_err;

  modport master (
    output rx_data, rx_flag,
    input  fifo_data, push, n_size, start_mxv, resend, comando, frame_err
  );

  modport slave (
    input  rx_data, rx_flag,
    output fifo_data, push, n_size, start_mxv, resend, comando, frame_err
  );
endinterface

// File: rtl/mxv_cmd_parser.sv
// Frame parser for the UART command stream: FE, L, CMD, payload, EF.
// Routes matrix/vector payload to one-hot FIFO pushes and raises control pulses on accept.
module mxv_cmd_parser #(
  parameter int DW   = 8,
  parameter int NMAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  mxv_cmd_parser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_DATA,
    S_SKIP,
    S_END
  } state_t;

  localparam int RW = $clog2(NMAX + 1);
  localparam int LW = DW + 8;
  localparam logic [DW-1:0] SOF_BYTE = DW'(8'hFE);
  localparam logic [DW-1:0] EOF_BYTE = DW'(8'hEF);

  localparam logic [2:0] CMD_SET_N  = 3'd1;
  localparam logic [2:0] CMD_RESEND = 3'd2;
  localparam logic [2:0] CMD_MATRIX = 3'd3;
  localparam logic [2:0] CMD_VECTOR = 3'd4;
  localparam logic [2:0] CMD_START  = 3'd5;

  state_t          state_q, state_d;
  logic [DW-1:0]   len_q, len_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [DW-1:0]   n_pend_q, n_pend_d;
  logic [3:0]      n_size_q, n_size_d;
  logic [NMAX:0]   push_q, push_d;
  logic [DW-1:0]   fifo_data_q, fifo_data_d;
  logic            start_q, start_d;
  logic            resend_q, resend_d;
  logic [2:0]      comando_q, comando_d;
  logic            frame_err_q, frame_err_d;

  logic [LW-1:0]   exp_len;
  logic            cmd_ok;
  logic            n_pend_ok;

  // Expected L for the command byte currently on rx_data, at the N in force now.
  always_comb begin
    exp_len = '0;
    case (bus.rx_data)
      DW'(8'h01): exp_len = LW'(2);
      DW'(8'h02): exp_len = LW'(1);
      DW'(8'h03): exp_len = LW'(n_size_q) * LW'(n_size_q) + LW'(1);
      DW'(8'h04): exp_len = LW'(n_size_q) + LW'(1);
      DW'(8'h05): exp_len = LW'(1);
      default:    exp_len = '0;
    endcase
  end

  assign cmd_ok    = (exp_len != '0) && (LW'(len_q) == exp_len);
  assign n_pend_ok = (n_pend_q >= DW'(2)) && (n_pend_q <= DW'(NMAX));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    rem_d       = rem_q;
    row_d       = row_q;
    col_d       = col_q;
    n_pend_d    = n_pend_q;
    n_size_d    = n_size_q;
    push_d      = '0;
    fifo_data_d = fifo_data_q;
    start_d     = 1'b0;
    resend_d    = 1'b0;
    comando_d   = comando_q;
    frame_err_d = 1'b0;

    if (bus.rx_flag) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SOF_BYTE) state_d = S_LEN;
        end

        S_LEN: begin
          len_d = bus.rx_data;
          if (bus.rx_data == '0) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_CMD;
          end
        end

        S_CMD: begin
          cmd_d = bus.rx_data[2:0];
          rem_d = len_q - DW'(1);
          if (cmd_ok) begin
            row_d   = '0;
            col_d   = '0;
            state_d = (len_q == DW'(1)) ? S_END : S_DATA;
          end else begin
            // rem counts payload still to discard; the end byte follows when it hits zero.
            frame_err_d = 1'b1;
            state_d     = S_SKIP;
          end
        end

        S_DATA: begin
          case (cmd_q)
            CMD_MATRIX: begin
              push_d[row_q] = 1'b1;
              fifo_data_d   = bus.rx_data;
              if (col_q == n_size_q - 4'd1) begin
                col_d = '0;
                row_d = row_q + RW'(1);
              end else begin
                col_d = col_q + 4'd1;
              end
            end
            CMD_VECTOR: begin
              push_d[NMAX] = 1'b1;
              fifo_data_d  = bus.rx_data;
            end
            CMD_SET_N: n_pend_d = bus.rx_data;
            default: ;
          endcase
          rem_d = rem_q - DW'(1);
          if (rem_q == DW'(1)) state_d = S_END;
        end

        S_SKIP: begin
          if (rem_q == '0) state_d = S_IDLE;
          else             rem_d   = rem_q - DW'(1);
        end

        S_END: begin
          state_d = S_IDLE;
          if (bus.rx_data == EOF_BYTE) begin
            comando_d = cmd_q;
            case (cmd_q)
              CMD_SET_N: begin
                if (n_pend_ok) n_size_d    = n_pend_q[3:0];
                else           frame_err_d = 1'b1;
              end
              CMD_RESEND: resend_d = 1'b1;
              CMD_START:  start_d  = 1'b1;
              default: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cmd_q       <= '0;
      rem_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      n_pend_q    <= '0;
      n_size_q    <= 4'd2;
      push_q      <= '0;
      fifo_data_q <= '0;
      start_q     <= 1'b0;
      resend_q    <= 1'b0;
      comando_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      rem_q       <= rem_d;
      row_q       <= row_d;
      col_q       <= col_d;
      n_pend_q    <= n_pend_d;
      n_size_q    <= n_size_d;
      push_q      <= push_d;
      fifo_data_q <= fifo_data_d;
      start_q     <= start_d;
      resend_q    <= resend_d;
      comando_q   <= comando_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.push      = push_q;
  assign bus.fifo_data = fifo_data_q;
  assign bus.n_size    = n_size_q;
  assign bus.start_mxv = start_q;
  assign bus.resend    = resend_q;
  assign bus.comando   = comando_q;
  assign bus.frame_err = frame_err_q;

endmodule
